// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: memory-mapped 8N1 UART receiver with an RX FIFO.
// Registers (addr[3:2]): 0 DATA (RO, read pops), 1 STATUS (RO, read clears
// sticky flags), 2 DIV (RW, clock cycles per bit, minimum 4), 3 reserved.
//
// Bus handshake: sel is a single-cycle request with no backpressure. Every
// access sampled with sel = 1 at a rising edge is answered by ack = 1 for
// exactly one cycle after that edge, with rdata valid alongside it. rdata is
// 0 whenever ack is 0 and for write acknowledgements.
module uart_rx_mmio #(
    parameter int DEFAULT_DIV = 868,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx_i,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        irq
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] DIV_RESET = 16'(DEFAULT_DIV);
    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // Receiver state is kept in one named signal so checkers can bind to it.
    rx_state_t state_q, state_n;

    logic [15:0] cnt_q, cnt_n;
    logic [15:0] bit_div_q, bit_div_n;
    logic [2:0]  bit_idx_q, bit_idx_n;
    logic [7:0]  shift_q, shift_n;
    logic        push_req;
    logic        ferr_set;

    logic        rx_s1, rx_s2, rx_prev;
    logic        rx_fall;

    logic [15:0] div_q;
    logic        overrun_q, frame_err_q;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count_q, count_n;
    logic        fifo_full, fifo_empty;
    logic        do_push, do_pop;
    logic        overrun_set;

    logic        rd_access, wr_access;
    logic        status_clr;
    logic [31:0] read_val;
    logic [3:0]  count4;

    logic        unused_bits;
    assign unused_bits = ^{wdata[31:16], addr[1:0]};

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev & ~rx_s2;

    // Receiver FSM state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_div_q <= DIV_RESET;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            bit_div_q <= bit_div_n;
            bit_idx_q <= bit_idx_n;
            shift_q   <= shift_n;
        end
    end

    // Receiver next-state logic: half-bit wait to mid start bit, then
    // one full bit period between each data/stop sample.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        bit_div_n = bit_div_q;
        bit_idx_n = bit_idx_q;
        shift_n   = shift_q;
        push_req  = 1'b0;
        ferr_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_fall) begin
                    // Divisor is frozen per frame; DIV writes apply at the next start bit.
                    bit_div_n = div_q;
                    cnt_n     = {1'b0, div_q[15:1]} - 16'd1;
                    state_n   = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == 16'd0) begin
                    if (!rx_s2) begin
                        cnt_n     = bit_div_q - 16'd1;
                        bit_idx_n = 3'd0;
                        state_n   = ST_DATA;
                    end else begin
                        // Line was high again at mid start bit: treat as a glitch.
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == 16'd0) begin
                    shift_n = {rx_s2, shift_q[7:1]};
                    cnt_n   = bit_div_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_n = ST_STOP;
                    end else begin
                        bit_idx_n = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_n = cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == 16'd0) begin
                    if (rx_s2) begin
                        push_req = 1'b1;
                    end else begin
                        ferr_set = 1'b1;
                    end
                    // Back to IDLE; a held-low line needs a fresh falling edge.
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt_q - 16'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign rd_access  = sel & ~we;
    assign wr_access  = sel & we;
    assign fifo_full  = (count_q == FULL_COUNT);
    assign fifo_empty = (count_q == '0);
    assign do_pop     = rd_access & (addr[3:2] == 2'b00) & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push    = push_req & (~fifo_full | do_pop);
    assign overrun_set = push_req & fifo_full & ~do_pop;
    assign status_clr = rd_access & (addr[3:2] == 2'b01);

    // Next occupancy count from simultaneous push and pop.
    always_comb begin
        count_n = count_q;
        if (do_push && !do_pop) begin
            count_n = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_n = count_q - 1'b1;
        end
    end

    // FIFO storage; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shift_q;
        end
    end

    // FIFO pointers, count and interrupt; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            irq     <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_n;
            irq     <= (count_n != '0);
        end
    end

    // Sticky error flags: a set from the receiver wins over a STATUS read clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= (overrun_q & ~status_clr) | overrun_set;
            frame_err_q <= (frame_err_q & ~status_clr) | ferr_set;
        end
    end

    // Divisor register with a floor of 4 so the half-bit count stays positive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= DIV_RESET;
        end else if (wr_access && addr[3:2] == 2'b10) begin
            div_q <= (wdata[15:0] < DIV_MIN) ? DIV_MIN : wdata[15:0];
        end
    end

    assign count4 = 4'(count_q);

    // Read data mux for the addressed register.
    always_comb begin
        read_val = '0;
        case (addr[3:2])
            2'b00: read_val = fifo_empty ? 32'd0 : {24'd0, mem[rd_ptr]};
            2'b01: read_val = {24'd0, count4, frame_err_q, ~fifo_empty, overrun_q, 1'b0};
            2'b10: read_val = {16'd0, div_q};
            default: read_val = '0;
        endcase
    end

    // Bus response: one-cycle ack, rdata only carries read results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= sel;
            rdata <= rd_access ? read_val : 32'd0;
        end
    end

endmodule

// File: doc/uart_rx_mmio.md
Name: uart_rx_mmio

Overview:
- Memory-mapped UART receiver peripheral at base 0x10013000.
- Responds to CPU load/store polling loops: the CPU reads STATUS (offset 0x4) until bit 2 (rx_valid) is set, then reads DATA (offset 0x0).
- Deserialises 8N1 frames from the rx pin into an RX FIFO.
- Exposes DATA, STATUS and DIV registers over a simple single-beat bus.

Parameters:
- DEFAULT_DIV, 868: reset value of the clock-cycles-per-bit divisor (100 MHz / 115200).
- FIFO_DEPTH, 8: RX FIFO entries. Power of two, 2..8.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- uart_rx_i  input  1  serial line, idle high, asynchronous to clk
- sel  input  1  bus access strobe, one cycle per access
- we  input  1  1 = write, 0 = read; qualified by sel
- addr  input  4  byte offset within block; addr[3:2] selects register
- wdata  input  32  write data
- rdata  output  32  read data, valid when ack = 1
- ack  output  1  access complete, one-cycle pulse
- irq  output  1  high while FIFO non-empty

Behaviour:
- Reset (async, rst = 1):
  - rdata = 0, ack = 0, irq = 0.
  - FIFO emptied; overrun and frame_err flags cleared.
  - DIV = DEFAULT_DIV; RX FSM = IDLE; synchroniser flops set to 1.
- Reset mid-frame: the partial byte is discarded; reception restarts at the next falling edge after rst deasserts.
- Bus:
  - sel sampled at posedge; ack and rdata are registered and appear the following cycle (latency 1).
  - sel is never held by master across ack; back-to-back accesses are allowed on consecutive cycles.
  - When ack = 0, rdata returns to 0.
- Register map:
  - 0x0 DATA (RO):
    - rdata[7:0] = FIFO head; upper bits 0.
    - A read pops the head when non-empty.
    - Empty read returns 0 with no side effect.
    - Writes are ignored and acked.
  - 0x4 STATUS (RO):
    - bit1 = overrun (sticky), bit2 = rx_valid (FIFO non-empty), bit3 = frame_err (sticky), bits[7:4] = FIFO count; all other bits 0.
    - A read returns the current value, then clears overrun and frame_err on the same edge that asserts ack.
    - A flag set by the FSM on that same edge survives the clear (set wins).
  - 0x8 DIV (RW): bits[15:0] are the divisor. Written values < 4 are stored as 4. Upper bits read 0.
  - 0xC: reads 0, writes ignored, ack still issued.
- Receiver input: uart_rx_i passes through a 2-flop synchroniser; a third flop holds the previous synced value for edge detection.
- RX FSM:
  - IDLE: on a synced 1->0 transition, latch the current DIV as bit_div, load cnt = bit_div/2 - 1, go to START. The start-bit sample therefore lands at mid-bit.
  - START: when cnt reaches 0, sample the line.
    - 0: load cnt = bit_div - 1, bit index = 0, go to DATA.
    - 1: glitch; go to IDLE, nothing recorded.
  - DATA: at each cnt = 0, shift the sample in LSB first and reload cnt. After bit 7, go to STOP.
  - STOP: at cnt = 0, sample the line.
    - 1: push byte.
    - 0: set frame_err, discard byte.
    - Either way go to IDLE. A new frame needs a fresh falling edge, so a held-low break does not retrigger.
- DIV writes mid-frame take effect from the next start bit.
- FIFO:
  - Push when full: byte dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle: both occur; count unchanged; no overrun even when full.
  - Pointers wrap modulo FIFO_DEPTH.
- irq = registered (count != 0); it updates the cycle after a push or pop.

Test Plan:
- DIV = 16, send 0xA5 (8N1) -> within 10 bit-times + 3 cycles, STATUS reads 0x00000014. DATA reads 0x000000A5. STATUS then reads 0x00000000; irq falls.
- Empty FIFO, read DATA -> rdata = 0, ack one cycle after sel; STATUS still 0x0. Write 0xFF to DATA -> acked, no effect.
- DIV = 16, send bytes 0x01..0x09 with no reads (depth 8) -> STATUS = 0x00000086. Eight DATA reads return 0x01..0x08 in order. The next STATUS read = 0x00000000 (overrun cleared by the prior read).
- Frame 0x3C with stop bit driven 0 -> STATUS = 0x00000008, count 0. Second STATUS read = 0x0. A following valid 0x3C frame is received normally.
- Low glitch of 3 cycles with DIV = 16 -> no push, no flags. Write DIV = 2 -> reads back 4. Assert rst mid-data-bit -> all outputs 0, DIV = 868, a following frame at DIV = 868 is received correctly.
- FIFO full and DATA read on the exact stop-bit push cycle -> no overrun; count stays 8; the new byte appears last in read order.
